uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 80 ++++++++
 tb/tb_uart_tx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first serial transmitter with internal baud divider.
// One byte per request; tx idles high and every line output is registered.
module uart_tx #(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int DIVISOR = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dato,
    input  logic       enviar,
    output logic       tx,
    output logic       ocupado,
    output logic       hecho
);
    localparam int CW = $clog2(DIVISOR);

    typedef enum logic [1:0] {ESPERAR, INICIO, DATOS, PARADA} estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sr;
    logic          fin;

    assign fin = cnt == CW'(DIVISOR - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= ESPERAR;
            cnt     <= '0;
            idx     <= '0;
            sr      <= '0;
            tx      <= 1'b1;
            ocupado <= 1'b0;
            hecho   <= 1'b0;
        end else begin
            hecho <= 1'b0;
            case (estado)
                ESPERAR: if (enviar) begin
                    estado  <= INICIO;
                    sr      <= dato;
                    cnt     <= '0;
                    idx     <= '0;
                    tx      <= 1'b0;
                    ocupado <= 1'b1;
                end
                INICIO: begin
                    cnt <= fin ? '0 : cnt + 1'b1;
                    if (fin) begin
                        estado <= DATOS;
                        tx     <= sr[0];
                    end
                end
                DATOS: begin
                    cnt <= fin ? '0 : cnt + 1'b1;
                    if (fin) begin
                        idx <= idx + 1'b1;
                        sr  <= sr >> 1;
                        tx  <= (idx == 3'd7) ? 1'b1 : sr[1];
                        if (idx == 3'd7) estado <= PARADA;
                    end
                end
                PARADA: begin
                    cnt <= fin ? '0 : cnt + 1'b1;
                    if (fin) begin
                        estado  <= ESPERAR;
                        ocupado <= 1'b0;
                        hecho   <= 1'b1;
                    end
                end
                default: begin
                    estado  <= ESPERAR;
                    tx      <= 1'b1;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx at DIVISOR=4 plus one frame at default parameters.
module tb_uart_tx;
    localparam int D  = 4;
    localparam int DD = 434;

    logic       clk = 1'b0;
    logic       rst, enviar, enviar1;
    logic [7:0] dato, dato1;
    logic       tx, ocupado, hecho;
    logic       tx1, ocupado1, hecho1;
    int         checks = 0;
    int         failures = 0;

    uart_tx #(.CLK_HZ(460800), .BAUD(115200)) dut (
        .clk(clk), .rst(rst), .dato(dato), .enviar(enviar),
        .tx(tx), .ocupado(ocupado), .hecho(hecho)
    );

    uart_tx dut_def (
        .clk(clk), .rst(rst), .dato(dato1), .enviar(enviar1),
        .tx(tx1), .ocupado(ocupado1), .hecho(hecho1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First tick is the acceptance edge; inj>=0 raises a busy-time request at that sample.
    task automatic frame(input logic [7:0] b, input bit hold, input int inj, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        tick();
        if (!hold) enviar = 1'b0;
        for (int k = 0; k < 10 * D; k++) begin
            if (k == inj) begin
                enviar = 1'b1;
                dato   = 8'h81;
            end
            if (inj >= 0 && k == inj + 5) enviar = 1'b0;
            chk({tag, "_tx"}, tx, bits[k / D]);
            chk({tag, "_ocupado"}, ocupado, 1);
            chk({tag, "_hecho"}, hecho, 0);
            tick();
        end
        chk({tag, "_end_tx"}, tx, 1);
        chk({tag, "_end_ocupado"}, ocupado, 0);
        chk({tag, "_end_hecho"}, hecho, 1);
    endtask

    initial begin
        int errs;
        logic [9:0] bits1;
        rst = 1'b1; enviar = 1'b1; dato = 8'h77; enviar1 = 1'b0; dato1 = 8'h00;
        tick();
        tick();
        chk("rst_tx", tx, 1);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_hecho", hecho, 0);
        chk("rst_def_tx", tx1, 1);
        rst = 1'b0; enviar = 1'b0; dato = 8'h00;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_tx", tx, 1);
            chk("idle_ocupado", ocupado, 0);
            chk("idle_hecho", hecho, 0);
        end

        dato = 8'hA5; enviar = 1'b1;
        frame(8'hA5, 1'b0, -1, "a5");
        tick();
        chk("a5_hecho_fall", hecho, 0);

        dato = 8'h00; enviar = 1'b1;
        frame(8'h00, 1'b1, -1, "b2b_00");
        dato = 8'hFF;
        frame(8'hFF, 1'b1, -1, "b2b_ff");
        enviar = 1'b0;
        tick();
        chk("b2b_hecho_fall", hecho, 0);
        chk("b2b_idle_ocupado", ocupado, 0);

        dato = 8'h3C; enviar = 1'b1;
        frame(8'h3C, 1'b0, 15, "busy");
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1 || ocupado !== 1'b0 || hecho !== 1'b0) errs++;
        end
        chk("busy_no_second", errs, 0);

        dato = 8'h55; enviar = 1'b1;
        tick();
        enviar = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("mid_bit3_tx", tx, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_ocupado", ocupado, 0);
        rst = 1'b0;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (hecho !== 1'b0 || ocupado !== 1'b0 || tx !== 1'b1) errs++;
        end
        chk("mid_no_hecho", errs, 0);
        dato = 8'h55; enviar = 1'b1;
        frame(8'h55, 1'b0, -1, "after_rst");

        bits1 = {1'b1, 8'h41, 1'b0};
        dato1 = 8'h41; enviar1 = 1'b1;
        tick();
        enviar1 = 1'b0;
        errs = 0;
        for (int k = 0; k < 10 * DD; k++) begin
            if (tx1 !== bits1[k / DD] || ocupado1 !== 1'b1 || hecho1 !== 1'b0) errs++;
            tick();
        end
        chk("def_frame_bits", errs, 0);
        chk("def_end_ocupado", ocupado1, 0);
        chk("def_end_hecho", hecho1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
